// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs31_checker
//  Purpose  : Serial PRBS31 (x^31 + x^28 + 1) pattern checker. Hunts for
//             alignment by filling its register from the line and then
//             verifying 64 consecutive predictions before declaring lock.
//             Once locked it runs self-synchronously, counts bit errors in a
//             saturating 16-bit counter and drops lock after 16 errors in a
//             256-bit window.
//  Revision : 1.0  initial release
//
//  Ports
//    clk      in   1  sole clock, rising edge
//    rst_n    in   1  synchronous active-low reset
//    ui_in    in   8  [0] data, [1] valid, [2] clear, [3] counter byte
//                     select, [5] polarity invert (macro only)
//    uo_out   out  8  [0] locked, [1] bit-error pulse, [2] sticky lock-lost
//    uio_in   in   8  unused
//    uio_out  out  8  selected byte of the error counter
//    uio_oe   out  8  constant all-ones
//    ena      in   1  unused
//
//  Configuration
//    PRBS31_CHK_INVERT_EN  when defined, ui_in[5] inverts the received bit
// ============================================================================
module prbs31_checker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   logic d;
   logic valid;
   logic clr;
   logic sel;

   assign valid = ui_in[1];
   assign clr   = ui_in[2];
   assign sel   = ui_in[3];

`ifdef PRBS31_CHK_INVERT_EN
   assign d = ui_in[0] ^ ui_in[5];
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:6], ui_in[4]};
`else
   assign d = ui_in[0];
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};
`endif

   // Registered state
   state_t      state,     state_d;
   logic [30:0] r,         r_d;
   logic [4:0]  fill_cnt,  fill_d;
   logic [5:0]  match_cnt, match_d;
   logic [7:0]  win_cnt,   win_d;
   logic [4:0]  win_err,   win_err_d;
   logic [15:0] err_cnt,   err_cnt_d;
   logic        err_pulse;
   logic        lost,      lost_d;
   logic        locked;

   logic        p;
   logic        bit_err;
   logic        lock_loss;
   logic [4:0]  win_err_sum;

   assign p = r[30] ^ r[27];

   always_comb begin
      state_d     = state;
      r_d         = r;
      fill_d      = fill_cnt;
      match_d     = match_cnt;
      win_d       = win_cnt;
      win_err_d   = win_err;
      bit_err     = 1'b0;
      lock_loss   = 1'b0;
      win_err_sum = win_err;

      if (valid) begin
         case (state)
            HUNT: begin
               r_d = {r[29:0], d};
               if (fill_cnt == 5'd30) begin
                  fill_d  = 5'd0;
                  match_d = 6'd0;
                  state_d = VERIFY;
               end else begin
                  fill_d = fill_cnt + 5'd1;
               end
            end

            VERIFY: begin
               r_d = {r[29:0], d};
               // An all-zero register predicts zeros forever; reject it so
               // a dead line can never lock.
               if ((r == 31'd0) || (d != p)) begin
                  state_d = HUNT;
                  fill_d  = 5'd0;
               end else if (match_cnt == 6'd63) begin
                  state_d   = LOCKED;
                  match_d   = 6'd0;
                  win_d     = 8'd0;
                  win_err_d = 5'd0;
               end else begin
                  match_d = match_cnt + 6'd1;
               end
            end

            LOCKED: begin
               // Feed back the prediction so a line error is seen only once.
               r_d         = {r[29:0], p};
               bit_err     = d ^ p;
               win_err_sum = win_err + {4'd0, bit_err};
               win_d       = win_cnt + 8'd1;
               // Loss of lock is tested before the window wrap so a 16th
               // error on the last bit of a window still drops lock.
               if (win_err_sum == 5'd16) begin
                  state_d   = HUNT;
                  fill_d    = 5'd0;
                  lock_loss = 1'b1;
               end else if (win_cnt == 8'hFF) begin
                  win_err_d = 5'd0;
               end else begin
                  win_err_d = win_err_sum;
               end
            end

            default: begin
               state_d = HUNT;
               fill_d  = 5'd0;
            end
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt;
      lost_d    = lost | lock_loss;
      if (clr) begin
         err_cnt_d = 16'd0;
         lost_d    = 1'b0;
      end else if (bit_err && (err_cnt != 16'hFFFF)) begin
         err_cnt_d = err_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HUNT;
         r         <= 31'd0;
         fill_cnt  <= 5'd0;
         match_cnt <= 6'd0;
         win_cnt   <= 8'd0;
         win_err   <= 5'd0;
         err_cnt   <= 16'd0;
         err_pulse <= 1'b0;
         lost      <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_d;
         r         <= r_d;
         fill_cnt  <= fill_d;
         match_cnt <= match_d;
         win_cnt   <= win_d;
         win_err   <= win_err_d;
         err_cnt   <= err_cnt_d;
         err_pulse <= bit_err;
         lost      <= lost_d;
         locked    <= (state_d == LOCKED);
      end
   end

   assign uo_out  = {5'd0, lost, err_pulse, locked};
   assign uio_out = sel ? err_cnt[15:8] : err_cnt[7:0];
   assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs31_checker
//  Purpose  : Self-checking bench for prbs31_checker. A behavioural model
//             built from the checker's rules (bit history queue, counters)
//             predicts every output after each clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prbs31_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'd0;
   logic [7:0] uio_in = 8'd0;
   logic       ena = 1'b1;
   wire  [7:0] uo_out;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;

   int vectors = 0;
   int miscompares = 0;

   prbs31_checker dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   bit hist[$];      // last 31 bits of the reconstructed sequence, [0] oldest
   int m_mode;       // 0 hunt, 1 verify, 2 locked
   int m_fill, m_match, m_wbits, m_werrs;
   int m_errcnt;
   bit m_lost, m_pulse;

   logic [30:0] g;   // stimulus generator state

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 31; i++) hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
      m_errcnt = 0; m_lost = 0; m_pulse = 0;
   endtask

   task automatic push_bit(input bit b);
      bit dummy;
      hist.push_back(b);
      dummy = hist.pop_front();
   endtask

   task automatic model_step(input bit d, input bit valid, input bit clr);
      bit pred;
      int ones;
      m_pulse = 0;
      if (valid) begin
         pred = hist[0] ^ hist[3];   // bits received 31 and 28 ago
         if (m_mode == 0) begin
            push_bit(d);
            m_fill++;
            if (m_fill == 31) begin m_mode = 1; m_match = 0; end
         end else if (m_mode == 1) begin
            ones = 0;
            foreach (hist[i]) ones += int'(hist[i]);
            push_bit(d);
            if (ones == 0 || d != pred) begin
               m_mode = 0; m_fill = 0;
            end else begin
               m_match++;
               if (m_match == 64) begin m_mode = 2; m_wbits = 0; m_werrs = 0; end
            end
         end else begin
            push_bit(pred);
            if (d != pred) begin
               m_pulse = 1;
               if (m_errcnt < 65535) m_errcnt++;
               m_werrs++;
            end
            m_wbits++;
            if (m_werrs == 16) begin
               m_mode = 0; m_fill = 0; m_lost = 1;
            end else if (m_wbits == 256) begin
               m_wbits = 0; m_werrs = 0;
            end
         end
      end
      if (clr) begin m_errcnt = 0; m_lost = 0; end
   endtask

   function automatic logic [7:0] exp_uo();
      return {5'd0, m_lost, m_pulse, (m_mode == 2)};
   endfunction

   function automatic logic [7:0] exp_uio();
      return ui_in[3] ? m_errcnt[15:8] : m_errcnt[7:0];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic gen_bit(output logic b);
      b = g[30];
      g = {g[29:0], g[30] ^ g[27]};
   endtask

   task automatic drive(input logic data, input logic valid, input logic clr,
                        input logic sel, input logic inv);
      bit d_eff;
      @(negedge clk);
      ui_in = {2'b00, inv, 1'b0, sel, clr, valid, data};
      @(posedge clk);
`ifdef PRBS31_CHK_INVERT_EN
      d_eff = data ^ inv;
`else
      d_eff = data;
`endif
      model_step(d_eff, valid, clr);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = 8'($urandom) | 8'h06;   // valid and clear asserted under reset
      @(posedge clk);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic lock_up();
      logic b;
      g = 31'h1;
      for (int i = 0; i < 95; i++) begin
         gen_bit(b);
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         do_reset();
         vectors++;
         if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h, need 00 00 ff",
                     uo_out, uio_out, uio_oe);
         end
      end
   endtask

   task automatic test_lock();
      logic b;
      do_reset();
      g = 31'h1;
      for (int i = 1; i <= 295; i++) begin
         gen_bit(b);
         drive(b, 1'b1, 1'b0, 1'($urandom), 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uio_out !== exp_uio() || uo_out[0] !== (i >= 95)) begin
            miscompares++;
            $display("FAIL lock bit=%0d: uo_out=%h uio_out=%h, need %h %h",
                     i, uo_out, uio_out, exp_uo(), exp_uio());
         end
      end
   endtask

   task automatic test_single_error();
      logic b;
      do_reset();
      lock_up();
      for (int i = 0; i < 20; i++) begin gen_bit(b); drive(b, 1'b1, 1'b0, 1'b0, 1'b0); end
      gen_bit(b);
      drive(~b, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (uo_out !== exp_uo() || uo_out[1:0] !== 2'b11 || uio_out !== 8'd1) begin
         miscompares++;
         $display("FAIL single_err: uo_out=%h uio_out=%h, need %h 01", uo_out, uio_out, exp_uo());
      end
      gen_bit(b);
      drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (uo_out !== exp_uo() || uo_out[1:0] !== 2'b01) begin
         miscompares++;
         $display("FAIL single_err_after: uo_out=%h, need %h", uo_out, exp_uo());
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (uio_out !== exp_uio() || uio_out !== 8'd0) begin
         miscompares++;
         $display("FAIL single_err_hi: uio_out=%h, need %h", uio_out, exp_uio());
      end
   endtask

   task automatic test_valid_hold();
      logic b;
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uio_out !== exp_uio() || uo_out[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL valid_hold cyc=%0d: uo_out=%h uio_out=%h, need %h %h",
                     i, uo_out, uio_out, exp_uo(), exp_uio());
         end
      end
      for (int i = 0; i < 40; i++) begin
         gen_bit(b);
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
            miscompares++;
            $display("FAIL valid_resume cyc=%0d: uo_out=%h uio_out=%h, need %h %h",
                     i, uo_out, uio_out, exp_uo(), exp_uio());
         end
      end
   endtask

   task automatic test_loss();
      logic b;
      int flips = 0;
      do_reset();
      lock_up();
      for (int k = 0; k < 200 && flips < 16; k++) begin
         gen_bit(b);
         if ($urandom_range(0, 11) == 0 || (199 - k) < (16 - flips)) begin
            b = ~b; flips++;
         end
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
            miscompares++;
            $display("FAIL loss k=%0d: uo_out=%h uio_out=%h, need %h %h",
                     k, uo_out, uio_out, exp_uo(), exp_uio());
         end
      end
      vectors++;
      if (uo_out[2] !== 1'b1 || uo_out[0] !== 1'b0 || uio_out !== 8'd16) begin
         miscompares++;
         $display("FAIL loss_state: uo_out=%h uio_out=%h, need lost=1 locked=0 cnt=10", uo_out, uio_out);
      end
      for (int i = 1; i <= 95; i++) begin
         gen_bit(b);
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uo_out[0] !== (i == 95) || uo_out[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL relock bit=%0d: uo_out=%h, need %h", i, uo_out, exp_uo());
         end
      end
   endtask

   task automatic test_clear();
      logic b;
      gen_bit(b);
      drive(~b, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (uo_out !== exp_uo() || uio_out !== 8'd0 || uo_out[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_lo: uo_out=%h uio_out=%h, need %h 00", uo_out, uio_out, exp_uo());
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (uio_out !== 8'd0 || uio_out !== exp_uio()) begin
         miscompares++;
         $display("FAIL clear_hi: uio_out=%h, need 00", uio_out);
      end
   endtask

   task automatic test_window_wrap();
      logic b;
      do_reset();
      lock_up();
      // window 1: 15 errors then clean to the wrap; window 2: 15 early
      // errors plus one on its final bit
      for (int w = 0; w < 2; w++) begin
         for (int k = 1; k <= 256; k++) begin
            gen_bit(b);
            if (k <= 15 || (w == 1 && k == 256)) b = ~b;
            drive(b, 1'b1, 1'b0, 1'($urandom), 1'b0);
            vectors++;
            if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
               miscompares++;
               $display("FAIL window w=%0d k=%0d: uo_out=%h uio_out=%h, need %h %h",
                        w, k, uo_out, uio_out, exp_uo(), exp_uio());
            end
         end
         vectors++;
         if (uo_out[0] !== (w == 0) || uo_out[2] !== (w == 1)) begin
            miscompares++;
            $display("FAIL window_end w=%0d: uo_out=%h, need locked=%0d lost=%0d",
                     w, uo_out, (w == 0), (w == 1));
         end
      end
   endtask

   task automatic test_zeros();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
         vectors++;
         if (uo_out !== exp_uo() || uo_out[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL zeros cyc=%0d: uo_out=%h, need %h", i, uo_out, exp_uo());
         end
      end
   endtask

   task automatic test_mid_lock_reset();
      logic b;
      do_reset();
      lock_up();
      do_reset();
      vectors++;
      if (uo_out !== 8'h00) begin
         miscompares++;
         $display("FAIL midlock_reset: uo_out=%h, need 00", uo_out);
      end
      for (int i = 1; i <= 95; i++) begin
         gen_bit(b);
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (uo_out !== exp_uo()) begin
            miscompares++;
            $display("FAIL midlock_refill bit=%0d: uo_out=%h, need %h", i, uo_out, exp_uo());
         end
      end
   endtask

   task automatic test_invert();
      logic b;
      logic inv;
      do_reset();
      g = 31'h1;
      for (int i = 1; i <= 150; i++) begin
         gen_bit(b);
`ifdef PRBS31_CHK_INVERT_EN
         inv = 1'b1;
         b   = ~b;
`else
         inv = 1'($urandom);
`endif
         drive(b, 1'b1, 1'b0, 1'b0, inv);
         vectors++;
         if (uo_out !== exp_uo() || uo_out[0] !== (i >= 95) || uio_out !== 8'd0) begin
            miscompares++;
            $display("FAIL invert bit=%0d: uo_out=%h uio_out=%h, need %h 00",
                     i, uo_out, uio_out, exp_uo());
         end
      end
   endtask

   task automatic test_random();
      logic b;
      logic v;
      do_reset();
      g = 31'($urandom) | 31'd1;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 4) != 0);
         if (v) begin
            gen_bit(b);
            if ($urandom_range(0, 79) == 0) b = ~b;
         end else begin
            b = 1'($urandom);
         end
         drive(b, v, ($urandom_range(0, 199) == 0), 1'($urandom), 1'b0);
         vectors++;
         if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
            miscompares++;
            $display("FAIL random cyc=%0d: uo_out=%h uio_out=%h, need %h %h",
                     i, uo_out, uio_out, exp_uo(), exp_uio());
         end
      end
   endtask

   initial begin
      uio_in = 8'($urandom);
      model_reset();
      test_reset();
      test_lock();
      test_single_error();
      test_valid_hold();
      test_loss();
      test_clear();
      test_window_wrap();
      test_zeros();
      test_mid_lock_reset();
      test_invert();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, per the following port list.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 ui_in  input  8  [0] serial data bit; [1] bit valid; [2] synchronous clear; [3] counter byte select (0=low, 1=high); [5] polarity invert (only with macro, see REQ-031); others unused.
REQ-005 uo_out  output  8  [0] locked; [1] bit-error pulse; [2] sticky lock-lost; [7:3] 0.
REQ-006 uio_in  input  8  unused.
REQ-007 uio_out  output  8  selected byte of 16-bit error counter.
REQ-008 uio_oe  output  8  constant 8'hFF.
REQ-009 ena  input  1  ignored.

Function
REQ-010 Polynomial: x^31+x^28+1; 31-bit register r, prediction p = r[30] XOR r[27] computed before the shift, new bit enters r[0].
REQ-011 The bit is consumed only on an edge with valid=1; with valid=0, r, FSM, window and match counters SHALL hold.
REQ-012 FSM states: HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-013 HUNT: shift received bit d into r; count 31 valid bits; on the 31st, go to VERIFY with match count 0.
REQ-014 VERIFY: compare d to p and shift d; mismatch -> HUNT (fill count restarts at 0); 64 consecutive matches -> LOCKED.
REQ-015 VERIFY: if r is all-zero, transition to HUNT; an all-zero stream SHALL never lock.
REQ-016 LOCKED: shift p (not d) into r, so that each line error counts exactly once.
REQ-017 LOCKED: d != p is a bit error; uo_out[1] SHALL be high for exactly the next clock after each erroring bit.
REQ-018 Error counter: 16 bit, increments only on LOCKED bit errors, saturates at 16'hFFFF.
REQ-019 Loss of lock: 256-bit window counter and window error count, both zeroed on LOCKED entry and at each window wrap; window error count reaching 16 -> HUNT next edge, sets uo_out[2].
REQ-020 If the 16th error coincides with the window wrap, loss of lock SHALL take priority.
REQ-021 Clear (ui_in[2]=1) zeroes the error counter and uo_out[2]; it wins over a simultaneous increment and does not affect the FSM.
REQ-022 uo_out[0] SHALL be 1 exactly while in LOCKED, registered (rises the edge after the 64th match).
REQ-023 uio_out SHALL reflect ui_in[3] combinationally over the registered counter.
REQ-024 All outputs except uio_out SHALL be driven from registers.

Reset
REQ-025 rst_n=0 at an edge: r=0, FSM=HUNT, all counters 0, uo_out=0, uio_out=0.
REQ-026 Reset mid-LOCKED SHALL abort the lock immediately; the next valid bit restarts the fill.
REQ-027 Reset SHALL take priority over clear and valid.

Configuration
REQ-028 Macro PRBS31_CHK_INVERT_EN selects the polarity-invert feature.
REQ-029 With the macro defined: d = ui_in[0] XOR ui_in[5].
REQ-030 Without the macro: d = ui_in[0]; ui_in[5] is ignored.
REQ-031 Without the macro, the invert logic SHALL be absent.

Verification
REQ-032 Reset, then a PRBS31 stream from seed 31'h1 (serial bit = state[30]) with valid=1 -> uo_out[0]=1 the edge after the 95th bit; counter 0.
REQ-033 Locked, flip one bit -> uo_out[1] high one cycle; counter=1; uo_out[0] stays 1.
REQ-034 Locked, 16 flipped bits within 256 -> uo_out[0]=0, uo_out[2]=1, counter=16; relock 95 good bits later.
REQ-035 Locked, valid=0 for 10 cycles with random ui_in[0] -> no state, counter or output change.
REQ-036 Clear in the same cycle as an error -> counter reads 16'h0000 both bytes; continuous zeros from reset -> never locks.
REQ-037 With PRBS31_CHK_INVERT_EN and ui_in[5]=1, an inverted stream -> locks at 95 bits, 0 errors.
